// File: rtl/wiegand_rx_pkg.sv
// Shared types and default parameters for the Wiegand receiver.
package wiegand_rx_pkg;

  localparam int unsigned DEF_MAX_BITS    = 34;
  localparam int unsigned DEF_MIN_BITS    = 26;
  localparam int unsigned DEF_LEN_W       = 6;
  localparam int unsigned DEF_TIMEOUT_CYC = 5000;
  localparam int unsigned DEF_MIN_PULSE   = 20;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PULSE = 3'd1,
    ST_GAP   = 3'd2,
    ST_CLOSE = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

endpackage

// File: rtl/wiegand_rx_line_filter.sv
// Per-line 2-flop synchroniser and saturating low-time counter; flags
// releases of pulses that were (or were not) long enough to count as a bit.
module wiegand_rx_line_filter
  import wiegand_rx_pkg::*;
#(
  parameter int unsigned MIN_PULSE = DEF_MIN_PULSE
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic line_low_o,
  output logic qual_release_c_o,
  output logic unqual_release_c_o
);

  localparam int unsigned CNT_W = $clog2(MIN_PULSE + 1);

  logic             sync_q;
  logic             low_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count low cycles; the count survives into the first high cycle only.
  always_comb begin
    cnt_d = '0;
    if (low_q) begin
      cnt_d = (cnt_q == CNT_W'(MIN_PULSE)) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= 1'b1;
      low_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= line_i;
      low_q  <= ~sync_q;
      cnt_q  <= cnt_d;
    end
  end

  assign line_low_o         = low_q;
  assign qual_release_c_o   = ~low_q & (cnt_q == CNT_W'(MIN_PULSE));
  assign unqual_release_c_o = ~low_q & (cnt_q != '0) & (cnt_q != CNT_W'(MIN_PULSE));

endmodule

// File: rtl/wiegand_rx.sv
// Length-agnostic Wiegand frame receiver: bit accumulation, frame timeout,
// parity check and held active-low interrupt, all on the system clock.
module wiegand_rx
  import wiegand_rx_pkg::*;
#(
  parameter int unsigned MAX_BITS    = DEF_MAX_BITS,
  parameter int unsigned MIN_BITS    = DEF_MIN_BITS,
  parameter int unsigned LEN_W       = DEF_LEN_W,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned MIN_PULSE   = DEF_MIN_PULSE
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic [1:0]          wil,
  input  logic                irq_ack,
  output logic [MAX_BITS-1:0] frame_data,
  output logic [LEN_W-1:0]    frame_len,
  output logic                parity_ok,
  output logic                frame_valid,
  output logic                eint,
  output logic                overrun,
  output logic                err_frame
);

  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYC);

  logic [1:0] line_low;
  logic [1:0] qual_rel_c;
  logic [1:0] unqual_rel_c;

  for (genvar g = 0; g < 2; g++) begin : g_line
    wiegand_rx_line_filter #(.MIN_PULSE(MIN_PULSE)) u_filter (
      .clk_i              (clk),
      .rst_ni             (nReset),
      .line_i             (wil[g]),
      .line_low_o         (line_low[g]),
      .qual_release_c_o   (qual_rel_c[g]),
      .unqual_release_c_o (unqual_rel_c[g])
    );
  end

  state_e              state_q, state_d;
  logic                sel_q, sel_d;
  logic [MAX_BITS-1:0] shift_q, shift_d;
  logic [LEN_W-1:0]    bitcnt_q, bitcnt_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [MAX_BITS-1:0] data_q, data_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                par_q, par_d;
  logic                fv_q, fv_d;
  logic                err_q, err_d;
  logic                eint_q, eint_d;
  logic                ovr_q, ovr_d;
  logic                other_low_c;
  logic                accept_c;
  logic                gap_done_c;

  // Leading bit gives even parity over the top h+1 bits, trailing bit odd over the bottom h+1.
  function automatic logic parity_calc(input logic [MAX_BITS-1:0] d, input logic [LEN_W-1:0] len);
    int unsigned l;
    int unsigned h;
    logic        ev;
    logic        od;
    l  = 32'(len);
    h  = (l - 32'd2) / 32'd2;
    ev = 1'b0;
    od = 1'b0;
    for (int unsigned i = 0; i < MAX_BITS; i++) begin
      if (i <= h) od = od ^ d[i];
      if ((i < l) && (i + h + 32'd1 >= l)) ev = ev ^ d[i];
    end
    return ~ev & od;
  endfunction

  assign other_low_c = sel_q ? line_low[0] : line_low[1];
  assign accept_c    = (bitcnt_q >= LEN_W'(MIN_BITS)) && (bitcnt_q <= LEN_W'(MAX_BITS));
  assign gap_done_c  = (gap_q == GAP_W'(TIMEOUT_CYC - 1));

  // Frame FSM; strobes are registered on the transition so they coincide with CLOSE.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    gap_d    = gap_q;
    data_d   = data_q;
    len_d    = len_q;
    par_d    = par_q;
    fv_d     = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (&line_low) begin
          state_d = ST_ERR;
          gap_d   = '0;
        end else if (|line_low) begin
          state_d = ST_PULSE;
          sel_d   = line_low[1];
        end
      end
      ST_PULSE: begin
        if (other_low_c) begin
          state_d = ST_ERR;
          gap_d   = '0;
        end else if (qual_rel_c[sel_q]) begin
          if (bitcnt_q <= LEN_W'(MAX_BITS)) begin
            shift_d  = {shift_q[MAX_BITS-2:0], sel_q};
            bitcnt_d = bitcnt_q + LEN_W'(1);
          end
          gap_d   = '0;
          state_d = ST_GAP;
        end else if (unqual_rel_c[sel_q]) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (&line_low) begin
          state_d = ST_ERR;
          gap_d   = '0;
        end else if (|line_low) begin
          state_d = ST_PULSE;
          sel_d   = line_low[1];
        end else if (gap_done_c) begin
          state_d = ST_CLOSE;
          if (accept_c) begin
            data_d = shift_q;
            len_d  = bitcnt_q;
            par_d  = parity_calc(shift_q, bitcnt_q);
            fv_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      ST_CLOSE: begin
        shift_d  = '0;
        bitcnt_d = '0;
        gap_d    = '0;
        state_d  = ST_IDLE;
      end
      ST_ERR: begin
        if (|line_low) begin
          gap_d = '0;
        end else if (gap_done_c) begin
          err_d    = 1'b1;
          shift_d  = '0;
          bitcnt_d = '0;
          gap_d    = '0;
          state_d  = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new frame outranks a simultaneous acknowledge.
  always_comb begin
    eint_d = eint_q;
    ovr_d  = ovr_q;
    if (fv_q) begin
      eint_d = 1'b0;
      ovr_d  = ~irq_ack & (~eint_q | ovr_q);
    end else if (irq_ack) begin
      eint_d = 1'b1;
      ovr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q  <= ST_IDLE;
      sel_q    <= 1'b0;
      shift_q  <= '0;
      bitcnt_q <= '0;
      gap_q    <= '0;
      data_q   <= '0;
      len_q    <= '0;
      par_q    <= 1'b0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
      eint_q   <= 1'b1;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      gap_q    <= gap_d;
      data_q   <= data_d;
      len_q    <= len_d;
      par_q    <= par_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
      eint_q   <= eint_d;
      ovr_q    <= ovr_d;
    end
  end

  assign frame_data  = data_q;
  assign frame_len   = len_q;
  assign parity_ok   = par_q;
  assign frame_valid = fv_q;
  assign err_frame   = err_q;
  assign eint        = eint_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_wiegand_rx.sv
// Directed and randomized frames against a bit-level model of Wiegand framing.
module tb_wiegand_rx;

  localparam int unsigned MAX_BITS  = 34;
  localparam int unsigned MIN_BITS  = 26;
  localparam int unsigned LEN_W     = 6;
  localparam int unsigned TIMEOUT   = 1000;
  localparam int unsigned MIN_PULSE = 20;
  // Two synchroniser stages plus gap timeout plus the CLOSE cycle, counted in negedges.
  localparam int          LAT       = TIMEOUT + 3;

  logic                clk = 1'b0;
  logic                nReset;
  logic [1:0]          wil;
  logic                irq_ack;
  logic [MAX_BITS-1:0] frame_data;
  logic [LEN_W-1:0]    frame_len;
  logic                parity_ok;
  logic                frame_valid;
  logic                eint;
  logic                overrun;
  logic                err_frame;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int err_cnt = 0;

  wiegand_rx #(
    .MAX_BITS(MAX_BITS), .MIN_BITS(MIN_BITS), .LEN_W(LEN_W),
    .TIMEOUT_CYC(TIMEOUT), .MIN_PULSE(MIN_PULSE)
  ) dut (
    .clk(clk), .nReset(nReset), .wil(wil), .irq_ack(irq_ack),
    .frame_data(frame_data), .frame_len(frame_len), .parity_ok(parity_ok),
    .frame_valid(frame_valid), .eint(eint), .overrun(overrun), .err_frame(err_frame)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (err_frame) err_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int w);
    if (b) wil[1] = 1'b0;
    else   wil[0] = 1'b0;
    idle(w);
    wil = 2'b11;
  endtask

  // First bit sent is v[len-1]; optional 5-cycle D1 glitch in the gap after bit glitch_at.
  task automatic send_frame(input logic [63:0] v, input int len, input bit rnd, input int glitch_at);
    for (int i = len - 1; i >= 0; i--) begin
      int pw;
      int gw;
      pw = rnd ? int'($urandom_range(40, 22)) : 25;
      gw = rnd ? int'($urandom_range(150, 30)) : 60;
      send_bit(v[i], pw);
      if (i == glitch_at) begin
        idle(20);
        wil[1] = 1'b0;
        idle(5);
        wil[1] = 1'b1;
      end
      if (i > 0) idle(gw);
    end
  endtask

  task automatic wait_evt(input int bound, output bit got_fv, output bit got_err, output int n);
    got_fv = 1'b0;
    got_err = 1'b0;
    n = 0;
    while (n < bound && !got_fv && !got_err) begin
      @(negedge clk);
      n++;
      got_fv = frame_valid;
      got_err = err_frame;
    end
  endtask

  function automatic logic [63:0] make_frame(input int len, input bit good);
    logic [63:0] v;
    int h;
    int ones;
    v = {$urandom, $urandom};
    v = v & ((64'd1 << len) - 64'd1);
    h = (len - 2) / 2;
    ones = 0;
    for (int k = 1; k <= h; k++) ones += int'(v[len-1-k]);
    v[len-1] = ones[0];
    ones = 0;
    for (int k = 1; k <= h; k++) ones += int'(v[k]);
    v[0] = ~ones[0];
    if (!good) v[0] = ~v[0];
    return v;
  endfunction

  // Leading group (first h+1 bits received) even, trailing group (last h+1) odd.
  function automatic logic exp_parity(input logic [63:0] v, input int len);
    int h;
    int top;
    int bot;
    h = (len - 2) / 2;
    top = 0;
    bot = 0;
    for (int k = 0; k <= h; k++) begin
      top += int'(v[len-1-k]);
      bot += int'(v[k]);
    end
    return ((top % 2) == 0) && ((bot % 2) == 1);
  endfunction

  task automatic chk_reset(input string tag);
    check({tag, "_data"}, 64'(frame_data), 64'd0);
    check({tag, "_len"}, 64'(frame_len), 64'd0);
    check({tag, "_par"}, 64'(parity_ok), 64'd0);
    check({tag, "_fv"}, 64'(frame_valid), 64'd0);
    check({tag, "_err"}, 64'(err_frame), 64'd0);
    check({tag, "_ovr"}, 64'(overrun), 64'd0);
    check({tag, "_eint"}, 64'(eint), 64'd1);
  endtask

  task automatic ack(input string tag);
    irq_ack = 1'b1;
    idle(1);
    irq_ack = 1'b0;
    check({tag, "_ack_eint"}, 64'(eint), 64'd1);
    check({tag, "_ack_ovr"}, 64'(overrun), 64'd0);
  endtask

  task automatic run_good(input int len, input bit good, input bit rnd, input int glitch_at,
                          input bit ack_on_fv, input string tag, output logic [63:0] v);
    bit gf;
    bit ge;
    int n;
    int c0;
    v = make_frame(len, good);
    c0 = fv_cnt;
    send_frame(v, len, rnd, glitch_at);
    wait_evt(LAT + 20, gf, ge, n);
    check({tag, "_fv"}, 64'(gf), 64'd1);
    check({tag, "_lat"}, 64'(n), 64'(LAT));
    check({tag, "_data"}, 64'(frame_data), v);
    check({tag, "_len"}, 64'(frame_len), 64'(len));
    check({tag, "_par"}, 64'(parity_ok), 64'(exp_parity(v, len)));
    if (ack_on_fv) irq_ack = 1'b1;
    idle(1);
    irq_ack = 1'b0;
    check({tag, "_fv_pulse"}, 64'(frame_valid), 64'd0);
    check({tag, "_eint_low"}, 64'(eint), 64'd0);
    idle(2);
    check({tag, "_fv_once"}, 64'(fv_cnt - c0), 64'd1);
  endtask

  task automatic run_bad(input int len, input string tag);
    logic [63:0] v;
    logic [63:0] d0;
    logic [63:0] l0;
    bit gf;
    bit ge;
    int n;
    v = make_frame(len, 1'b1);
    d0 = 64'(frame_data);
    l0 = 64'(frame_len);
    send_frame(v, len, 1'b0, -1);
    wait_evt(LAT + 20, gf, ge, n);
    check({tag, "_err"}, 64'(ge), 64'd1);
    check({tag, "_nofv"}, 64'(gf), 64'd0);
    check({tag, "_lat"}, 64'(n), 64'(LAT));
    idle(1);
    check({tag, "_err_pulse"}, 64'(err_frame), 64'd0);
    check({tag, "_data"}, 64'(frame_data), d0);
    check({tag, "_len"}, 64'(frame_len), l0);
    check({tag, "_eint"}, 64'(eint), 64'd1);
  endtask

  initial begin
    logic [63:0] v;
    bit gf;
    bit ge;
    int n;
    int f0;
    int e0;

    wil = 2'b11;
    irq_ack = 1'b0;
    nReset = 1'b0;
    idle(3);
    chk_reset("rst");
    nReset = 1'b1;
    idle(5);
    chk_reset("rst_rel");

    // 26-bit frame, valid parity; interrupt holds until acknowledged
    run_good(26, 1'b1, 1'b0, -1, 1'b0, "f26", v);
    idle(50);
    check("f26_eint_hold", 64'(eint), 64'd0);
    ack("f26");

    // 34-bit frame with trailing parity bit flipped
    run_good(34, 1'b0, 1'b0, -1, 1'b0, "f34bad", v);
    check("f34bad_par0", 64'(parity_ok), 64'd0);
    ack("f34bad");

    // Too short and too long frames are discarded
    run_bad(10, "f10");
    run_bad(40, "f40");

    // Short D1 glitch inside a frame is ignored
    run_good(26, 1'b1, 1'b0, 13, 1'b0, "glitch", v);
    ack("glitch");

    // Both lines low together -> error after idle, no frame
    f0 = fv_cnt;
    wil = 2'b00;
    idle(30);
    wil = 2'b11;
    wait_evt(LAT + 200, gf, ge, n);
    check("both_err", 64'(ge), 64'd1);
    check("both_nofv", 64'(fv_cnt - f0), 64'd0);
    check("both_eint", 64'(eint), 64'd1);

    // Back-to-back frames without ack -> overrun, data is the second frame
    run_good(int'($urandom_range(MAX_BITS, MIN_BITS)), 1'($urandom_range(1, 0)), 1'b1, -1, 1'b0, "ovA", v);
    check("ovA_ovr", 64'(overrun), 64'd0);
    run_good(int'($urandom_range(MAX_BITS, MIN_BITS)), 1'($urandom_range(1, 0)), 1'b1, -1, 1'b0, "ovB", v);
    check("ovB_ovr", 64'(overrun), 64'd1);
    ack("ovB");

    // Ack landing on the second frame_valid: the new frame wins
    run_good(int'($urandom_range(MAX_BITS, MIN_BITS)), 1'($urandom_range(1, 0)), 1'b1, -1, 1'b0, "ovC", v);
    run_good(int'($urandom_range(MAX_BITS, MIN_BITS)), 1'($urandom_range(1, 0)), 1'b1, -1, 1'b1, "ovD", v);
    check("ovD_ovr", 64'(overrun), 64'd0);

    // Reset after 12 bits discards the partial frame silently
    for (int i = 0; i < 12; i++) begin
      send_bit(1'($urandom_range(1, 0)), 25);
      idle(60);
    end
    nReset = 1'b0;
    idle(1);
    nReset = 1'b1;
    chk_reset("midrst");
    f0 = fv_cnt;
    e0 = err_cnt;
    idle(TIMEOUT + 100);
    check("midrst_nofv", 64'(fv_cnt - f0), 64'd0);
    check("midrst_noerr", 64'(err_cnt - e0), 64'd0);
    run_good(26, 1'b1, 1'b1, -1, 1'b0, "postrst", v);
    ack("postrst");

    // Random lengths, widths and parity
    for (int r = 0; r < 3; r++) begin
      run_good(int'($urandom_range(MAX_BITS, MIN_BITS)), 1'($urandom_range(1, 0)), 1'b1, -1, 1'b0,
               $sformatf("rnd%0d", r), v);
      ack($sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
